dnlink_pcm_ctrl: RTL and testbench



---
 rtl/dnlink_pcm_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_dnlink_pcm_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dnlink_pcm_ctrl.sv
// dnlink_pcm_ctrl: downlink PCM telemetry sequencer for the AGC.
//
// Divides the synchronised AGC CLK into bit slots and drives the DKSTRT,
// DKBSNC and DKEND strobes into the AGC downlink interface. DKDATA bits
// returned during the bit slots are assembled into NBITS-wide frames and
// queued in a small FIFO that the monitor drains over valid/ready.
//
// Ports
//   clk, rst          system clock, synchronous active-high reset
//   agc_clk_in        AGC CLK output, asynchronous to clk
//   enable            permits new frames; dropping it aborts the current frame
//   dkdata            AGC DKDATA, asynchronous to clk
//   dkstrt/dkbsnc/dkend  registered frame-start / bit-sync / frame-end strobes
//   frame_data        oldest buffered frame, first-received bit in the MSB
//   frame_valid       FIFO non-empty
//   frame_ready       consumer accepts frame_data
//   overflow_cnt      frames dropped on a full FIFO, saturating
//   busy              a frame is being sequenced
//
// state    | meaning
// ST_WAIT  | idle, waiting for slot 0 with enable set
// ST_START | slot 0, DKSTRT pulse
// ST_BITS  | slots 1..NBITS, DKBSNC pulse and DKDATA capture per slot
// ST_END   | slot NBITS+1, DKEND pulse; frame pushed at the end of the slot

module dnlink_pcm_ctrl #(
    parameter int PULSE_DIV   = 20,
    parameter int PULSE_WIDTH = 4,
    parameter int FRAME_SLOTS = 1024,
    parameter int NBITS       = 40,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             agc_clk_in,
    input  logic             enable,
    input  logic             dkdata,
    output logic             dkstrt,
    output logic             dkbsnc,
    output logic             dkend,
    output logic [NBITS-1:0] frame_data,
    output logic             frame_valid,
    input  logic             frame_ready,
    output logic [7:0]       overflow_cnt,
    output logic             busy
);

    localparam int TW = (PULSE_DIV > 1) ? $clog2(PULSE_DIV) : 1;
    localparam int SW = (FRAME_SLOTS > 1) ? $clog2(FRAME_SLOTS) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {ST_WAIT, ST_START, ST_BITS, ST_END} state_t;

    state_t            state, state_nxt;
    logic              agc_s1, agc_s2, agc_s3, dk_s1, dk_s2;
    logic              tick, slot_bnd, sample_pt, in_pulse;
    logic [TW-1:0]     pulse_timer, timer_nxt;
    logic [SW-1:0]     slot, slot_nxt;
    logic              strt_nxt, bsnc_nxt, end_nxt, push;
    logic [NBITS-1:0]  shreg;
    logic [NBITS-1:0]  fifo_q [FIFO_DEPTH];
    logic [CW-1:0]     count, count_nxt;
    logic [AW-1:0]     wr_idx;
    logic              pop, full, wr, drop;

    always_ff @(posedge clk) begin
        if (rst) begin
            agc_s1 <= 1'b0;
            agc_s2 <= 1'b0;
            agc_s3 <= 1'b0;
            dk_s1  <= 1'b0;
            dk_s2  <= 1'b0;
        end else begin
            agc_s1 <= agc_clk_in;
            agc_s2 <= agc_s1;
            agc_s3 <= agc_s2;
            dk_s1  <= dkdata;
            dk_s2  <= dk_s1;
        end
    end

    assign tick = agc_s2 & ~agc_s3;

    always_comb begin
        timer_nxt = pulse_timer;
        slot_nxt  = slot;
        slot_bnd  = 1'b0;
        if (tick) begin
            if (pulse_timer < TW'(PULSE_DIV - 1)) begin
                timer_nxt = pulse_timer + 1'b1;
            end else begin
                timer_nxt = '0;
                slot_bnd  = 1'b1;
                slot_nxt  = (slot == SW'(FRAME_SLOTS - 1)) ? '0 : slot + 1'b1;
            end
        end
    end

    // DKDATA is sampled on the tick that ends the strobe window.
    assign sample_pt = tick && (pulse_timer == TW'(PULSE_WIDTH - 1));
    assign in_pulse  = timer_nxt < TW'(PULSE_WIDTH);

    always_ff @(posedge clk) begin
        if (rst) begin
            pulse_timer <= '0;
            slot        <= SW'(FRAME_SLOTS - 1);
        end else begin
            pulse_timer <= timer_nxt;
            slot        <= slot_nxt;
        end
    end

    // The bit count is carried by the slot number itself: BITS occupies
    // slots 1..NBITS, so the last bit slot is recognised by its index.
    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        if (!enable) begin
            state_nxt = ST_WAIT;
        end else if (slot_bnd) begin
            case (state)
                ST_WAIT:  if (slot_nxt == '0) state_nxt = ST_START;
                ST_START: state_nxt = ST_BITS;
                ST_BITS:  if (slot == SW'(NBITS)) state_nxt = ST_END;
                ST_END: begin
                    state_nxt = ST_WAIT;
                    push      = 1'b1;
                end
                default:  state_nxt = ST_WAIT;
            endcase
        end
        strt_nxt = (state_nxt == ST_START) && in_pulse;
        bsnc_nxt = (state_nxt == ST_BITS)  && in_pulse;
        end_nxt  = (state_nxt == ST_END)   && in_pulse;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_WAIT;
            dkstrt <= 1'b0;
            dkbsnc <= 1'b0;
            dkend  <= 1'b0;
            busy   <= 1'b0;
        end else begin
            state  <= state_nxt;
            dkstrt <= strt_nxt;
            dkbsnc <= bsnc_nxt;
            dkend  <= end_nxt;
            busy   <= (state_nxt != ST_WAIT);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg <= '0;
        end else if (state == ST_BITS && sample_pt) begin
            shreg <= {shreg[NBITS-2:0], dk_s2};
        end
    end

    // Shift-register FIFO: entry 0 is always the head, so frame_data comes
    // straight from a flop. A pop and a push in the same cycle are both
    // honoured even when full, because the pop frees the top entry.
    assign pop       = frame_valid & frame_ready;
    assign full      = (count == CW'(FIFO_DEPTH));
    assign wr        = push & (~full | pop);
    assign drop      = push & full & ~pop;
    assign count_nxt = count + CW'(wr) - CW'(pop);
    assign wr_idx    = pop ? AW'(count - CW'(1)) : AW'(count);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
            count        <= '0;
            frame_valid  <= 1'b0;
            overflow_cnt <= '0;
        end else begin
            if (pop) begin
                for (int i = 0; i < FIFO_DEPTH - 1; i++) fifo_q[i] <= fifo_q[i+1];
            end
            if (wr) fifo_q[wr_idx] <= shreg;
            count       <= count_nxt;
            frame_valid <= (count_nxt != '0);
            if (drop && overflow_cnt != 8'hFF) overflow_cnt <= overflow_cnt + 1'b1;
        end
    end

    assign frame_data = fifo_q[0];

endmodule

// File: tb/tb_dnlink_pcm_ctrl.sv
// Bench for dnlink_pcm_ctrl. A reference model counts AGC ticks as plain
// integers (slot = ticks / div, timer = ticks % div), tracks whether a frame
// is active, and keeps the expected FIFO contents in a queue.
module tb_dnlink_pcm_ctrl;
    localparam int P_DIV        = 8;
    localparam int P_WIDTH      = 3;
    localparam int SLOTS        = 44;
    localparam int NB           = 40;
    localparam int DEPTH        = 4;
    localparam int FRAME_BUDGET = 2600;

    logic          clk = 1'b0;
    logic          rst, agc_clk_in, enable, dkdata, frame_ready;
    logic          dkstrt, dkbsnc, dkend, frame_valid, busy;
    logic [NB-1:0] frame_data;
    logic [7:0]    overflow_cnt;

    dnlink_pcm_ctrl #(
        .PULSE_DIV(P_DIV), .PULSE_WIDTH(P_WIDTH), .FRAME_SLOTS(SLOTS),
        .NBITS(NB), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .agc_clk_in(agc_clk_in), .enable(enable),
        .dkdata(dkdata), .dkstrt(dkstrt), .dkbsnc(dkbsnc), .dkend(dkend),
        .frame_data(frame_data), .frame_valid(frame_valid),
        .frame_ready(frame_ready), .overflow_cnt(overflow_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_pass   = 0;
    int            cyc      = 0;
    int            rise_q[$];
    logic [NB-1:0] exp_q[$];
    bit            agc_run  = 1'b0;
    bit            m_init   = 1'b0;
    bit            m_active = 1'b0;
    int            m_ticks  = 0;
    int            m_timer  = 0;
    int            m_slot   = SLOTS - 1;
    int            m_ovf    = 0;
    int            m_push_cnt = 0;
    int            m_starts = 0;
    logic [NB-1:0] cur_pat  = '0;
    logic [3:0]    exp_str  = '0;
    logic [63:0]   rnd;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Reference model. A rise driven on agc_clk_in is seen by the design
    // after the two synchroniser stages plus the edge detector, i.e. it is
    // acted on at the third rising clk edge after it was driven.
    always @(posedge clk) begin : model
        bit tick, bnd, pop, push;
        int s;
        cyc++;
        tick = 1'b0; bnd = 1'b0; pop = 1'b0; push = 1'b0;
        if (rise_q.size() > 0 && rise_q[0] == cyc) begin
            tick = 1'b1;
            void'(rise_q.pop_front());
        end
        if (rst) begin
            m_init = 1'b1; m_ticks = 0; m_active = 1'b0; m_ovf = 0;
            exp_q.delete();
        end else if (m_init) begin
            if (tick) m_ticks++;
            bnd = tick && (m_ticks % P_DIV == 0);
            s   = (SLOTS - 1 + m_ticks / P_DIV) % SLOTS;
            pop = frame_ready && (exp_q.size() > 0);
            if (!enable) begin
                m_active = 1'b0;
            end else if (bnd) begin
                if (m_active && s == (NB + 2) % SLOTS) begin
                    push = 1'b1; m_active = 1'b0; m_push_cnt++;
                end else if (!m_active && s == 0) begin
                    m_active = 1'b1;
                    if (m_starts == 0) cur_pat = 40'hA512345678;
                    else begin rnd = {$urandom, $urandom}; cur_pat = rnd[NB-1:0]; end
                    m_starts++;
                end
            end
            if (push && exp_q.size() >= DEPTH && !pop) begin
                if (m_ovf < 255) m_ovf++;
                push = 1'b0;
            end
            if (pop)  void'(exp_q.pop_front());
            if (push) exp_q.push_back(cur_pat);
        end
        m_timer = m_ticks % P_DIV;
        m_slot  = (SLOTS - 1 + m_ticks / P_DIV) % SLOTS;
        exp_str = {m_active,
                   m_active && m_slot == 0 && m_timer < P_WIDTH,
                   m_active && m_slot >= 1 && m_slot <= NB && m_timer < P_WIDTH,
                   m_active && m_slot == NB + 1 && m_timer < P_WIDTH};
    end

    always @(negedge clk) begin
        if (m_init) begin
            check("strobes", {busy, dkstrt, dkbsnc, dkend}, exp_str);
            check("frame_valid", frame_valid, exp_q.size() > 0);
            if (exp_q.size() > 0) check("frame_data", frame_data, exp_q[0]);
            check("overflow_cnt", overflow_cnt, m_ovf);
        end
    end

    // AGC clock with randomised half periods of 2..3 clk cycles.
    initial begin
        agc_clk_in = 1'b0;
        @(negedge clk);
        forever begin
            if (!agc_run) begin
                agc_clk_in = 1'b0;
                @(negedge clk);
            end else begin
                agc_clk_in = 1'b1;
                rise_q.push_back(cyc + 3);
                repeat ($urandom_range(2, 3)) @(negedge clk);
                agc_clk_in = 1'b0;
                repeat ($urandom_range(2, 3)) @(negedge clk);
            end
        end
    end

    // DKDATA: bit (NB - slot) of the current pattern during bit slots, noise elsewhere.
    initial begin
        dkdata = 1'b0;
        forever begin
            @(negedge clk);
            if (m_active && m_slot >= 1 && m_slot <= NB) dkdata = cur_pat[NB - m_slot];
            else dkdata = 1'($urandom_range(0, 1));
        end
    end

    task automatic wait_pushes(input int n);
        int target = m_push_cnt + n;
        int k = 0;
        while (m_push_cnt < target && k < (n + 1) * FRAME_BUDGET) begin
            @(negedge clk);
            k++;
        end
        if (m_push_cnt < target) check("push_timeout", m_push_cnt, target);
    endtask

    task automatic wait_slot(input int s);
        int k = 0;
        while (!(m_active && m_slot == s) && k < 2 * FRAME_BUDGET) begin
            @(negedge clk);
            k++;
        end
        if (!(m_active && m_slot == s)) check("slot_timeout", m_slot, s);
    endtask

    task automatic count_pops(input int cycles, output int pops);
        pops = 0;
        frame_ready = 1'b1;
        repeat (cycles) begin
            if (frame_valid) pops++;
            @(negedge clk);
        end
        frame_ready = 1'b0;
    endtask

    initial begin
        int pc, pops, k, ovf_before;
        rst = 1'b1; enable = 1'b0; frame_ready = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_valid", frame_valid, 1'b0);
        check("rst_ovf", overflow_cnt, 8'd0);
        check("rst_outputs", {busy, dkstrt, dkbsnc, dkend}, 4'b0);
        rst = 1'b0; enable = 1'b1; agc_run = 1'b1;

        wait_pushes(6);
        check("fill_ovf_two", overflow_cnt, 8'd2);
        check("fill_valid_held", frame_valid, 1'b1);
        check("first_frame_pattern", frame_data, 40'hA512345678);
        count_pops(8, pops);
        check("drain_count", pops, 4);

        pc = m_push_cnt; k = 0;
        while (m_push_cnt < pc + 2 && k < 3 * FRAME_BUDGET) begin
            frame_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            k++;
        end
        if (m_push_cnt < pc + 2) check("rand_ready_timeout", m_push_cnt, pc + 2);
        count_pops(8, pops);
        check("rand_drained", frame_valid, 1'b0);

        wait_pushes(4);
        check("full_valid", frame_valid, 1'b1);
        ovf_before = m_ovf;
        pc = m_push_cnt; k = 0;
        while (m_push_cnt == pc && k < 2 * FRAME_BUDGET) begin
            frame_ready = m_active && m_slot == NB + 1 && m_timer == P_DIV - 1 &&
                          rise_q.size() > 0 && rise_q[0] == cyc + 1;
            @(negedge clk);
            k++;
        end
        frame_ready = 1'b0;
        if (m_push_cnt == pc) check("coincident_timeout", m_push_cnt, pc + 1);
        check("coincident_ovf_same", overflow_cnt, ovf_before);
        count_pops(8, pops);
        check("coincident_count_four", pops, 4);

        wait_slot(20);
        repeat (5) @(negedge clk);
        check("abort_bsnc_before", dkbsnc, 1'b1);
        enable = 1'b0;
        @(negedge clk);
        check("abort_busy_low", busy, 1'b0);
        check("abort_strobes_low", {dkstrt, dkbsnc, dkend}, 3'b0);
        repeat (300) @(negedge clk);
        enable = 1'b1;
        k = 0;
        while (dkstrt !== 1'b1 && k < 2 * FRAME_BUDGET) begin
            @(negedge clk);
            k++;
        end
        check("restart_at_slot0", dkstrt, 1'b1);
        check("restart_slot", m_slot, 0);
        check("abort_no_frame", frame_valid, 1'b0);

        wait_pushes(2);
        check("two_queued", frame_valid, 1'b1);
        wait_slot(10);
        agc_run = 1'b0;
        repeat (12) @(negedge clk);
        check("mid_bits_busy", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_valid", frame_valid, 1'b0);
        check("midrst_ovf", overflow_cnt, 8'd0);
        check("midrst_outputs", {busy, dkstrt, dkbsnc, dkend}, 4'b0);
        check("midrst_data", frame_data, 40'h0);
        agc_run = 1'b1;
        wait_pushes(1);
        check("post_rst_frame", frame_data, cur_pat);

        repeat (6000) begin
            if ($urandom_range(0, 999) == 0) enable = ~enable;
            frame_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
        end
        enable = 1'b1; frame_ready = 1'b1;
        repeat (50) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
